// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the single-byte I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_NACK,
    ST_STOP
  } state_e;

  localparam int START_QUARTERS = 2;
  localparam int BIT_QUARTERS   = 4;
  localparam int STOP_QUARTERS  = 3;
  localparam int BITS_PER_BYTE  = 8;
  // sda_i is taken at the end of the first SCL-high quarter of a bit slot
  localparam int SAMPLE_QUARTER = 2;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period strobe: one-cycle tick every CLK_DIV enabled cycles, restartable.
module i2c_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));
  assign tick = en && !clr && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte (write or read), STOP.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i
);

  state_e     state_q, state_d;
  logic [1:0] q_q, q_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       samp_q, samp_d;
  logic       nack_q, nack_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       accept, tick;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    samp_d      = samp_q;
    nack_d      = nack_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;

    if (accept) begin
      state_d = ST_START;
      q_d     = '0;
      bit_d   = '0;
      tx_d    = {cmd_addr, cmd_rw};
      rw_d    = cmd_rw;
      wdata_d = cmd_wdata;
      rx_d    = '0;
      samp_d  = 1'b0;
      nack_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (tick) begin
      case (state_q)
        ST_START: begin
          if (q_q == 2'(START_QUARTERS - 1)) begin
            state_d = ST_ADDR;
            q_d     = '0;
            bit_d   = 3'(BITS_PER_BYTE - 1);
          end else q_d = q_q + 2'd1;
        end
        ST_STOP: begin
          if (q_q == 2'(STOP_QUARTERS - 1)) begin
            state_d     = ST_IDLE;
            q_d         = '0;
            busy_d      = 1'b0;
            rsp_valid_d = 1'b1;
          end else q_d = q_q + 2'd1;
        end
        ST_ADDR, ST_ADDR_ACK, ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_NACK: begin
          if (q_q == 2'(SAMPLE_QUARTER)) begin
            samp_d = sda_i;
            if (state_q == ST_RDATA) rx_d = {rx_q[6:0], sda_i};
          end
          if (q_q == 2'(BIT_QUARTERS - 1)) begin
            q_d   = '0;
            bit_d = bit_q - 3'd1;
            case (state_q)
              ST_ADDR: begin
                tx_d = {tx_q[6:0], 1'b0};
                if (bit_q == '0) state_d = ST_ADDR_ACK;
              end
              ST_ADDR_ACK: begin
                if (samp_q) begin
                  nack_d  = 1'b1;
                  state_d = ST_STOP;
                end else begin
                  bit_d   = 3'(BITS_PER_BYTE - 1);
                  tx_d    = wdata_q;
                  state_d = rw_q ? ST_RDATA : ST_WDATA;
                end
              end
              ST_WDATA: begin
                tx_d = {tx_q[6:0], 1'b0};
                if (bit_q == '0) state_d = ST_WDATA_ACK;
              end
              ST_WDATA_ACK: begin
                nack_d  = samp_q;
                state_d = ST_STOP;
              end
              ST_RDATA:      if (bit_q == '0) state_d = ST_RDATA_NACK;
              ST_RDATA_NACK: state_d = ST_STOP;
              default: ;
            endcase
          end else q_d = q_q + 2'd1;
        end
        default: ;
      endcase
    end

    // Bus levels follow the state/quarter being entered, so the pins change on quarter boundaries
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      ST_START: sda_d = (q_d == 2'd0);
      ST_ADDR, ST_WDATA: begin
        scl_d = q_d[1];
        sda_d = tx_d[7];
      end
      ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_RDATA_NACK: scl_d = q_d[1];
      ST_STOP: begin
        scl_d = (q_d != 2'd0);
        sda_d = (q_d == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      samp_q      <= 1'b0;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      samp_q      <= samp_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rx_q;
  assign rsp_nack  = nack_q;
  assign busy      = busy_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port cmd_addr, input, 7 bits: target slave address.
REQ-007 The block SHALL have port cmd_rw, input, 1 bit: 1 = read one byte, 0 = write one byte.
REQ-008 The block SHALL have port cmd_wdata, input, 8 bits: the write byte.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: one-cycle pulse at transaction end.
REQ-010 The block SHALL have port rsp_rdata, output, 8 bits: the read byte, valid with rsp_valid.
REQ-011 The block SHALL have port rsp_nack, output, 1 bit: the address or write-data was NACKed, valid with rsp_valid.
REQ-012 The block SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-013 The block SHALL have port scl_o, output, 1 bit: open-drain SCL; 0 drives low, 1 releases.
REQ-014 The block SHALL have port sda_o, output, 1 bit: open-drain SDA; 0 drives low, 1 releases.
REQ-015 The block SHALL have port sda_i, input, 1 bit: the sampled SDA line.

Function
REQ-016 A quarter-tick SHALL occur every CLK_DIV cycles; the counter runs only while busy and restarts at 0 on command accept.
REQ-017 cmd_ready SHALL equal "state is IDLE".
REQ-018 A command SHALL be accepted on cmd_valid && cmd_ready; the block SHALL capture addr, rw and wdata, set busy the next cycle, and ignore input changes thereafter.
REQ-019 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK and STOP.
REQ-020 START SHALL span 2 quarters:
- quarter 0: SCL=1, SDA=1.
- quarter 1: SCL=1, SDA=0.
REQ-021 Every bit slot SHALL span 4 quarters:
- q0: SCL=0, SDA set.
- q1: SCL=0.
- q2: SCL=1.
- q3: SCL=1.
- sda_i is sampled at the end of q2.
REQ-022 ADDR SHALL shift {cmd_addr, cmd_rw} MSB first, 8 slots.
REQ-023 ADDR_ACK SHALL release SDA and sample it; sample 1 sets the NACK flag and goes to STOP.
REQ-024 On address ACK the FSM SHALL go to WDATA (rw=0) or RDATA (rw=1).
REQ-025 WDATA SHALL shift wdata MSB first; WDATA_ACK SHALL sample the ACK, set the NACK flag on 1, then go to STOP.
REQ-026 RDATA SHALL release SDA and shift the samples in MSB first.
REQ-027 RDATA_NACK SHALL release SDA (master NACK) and then go to STOP.
REQ-028 STOP SHALL span 3 quarters:
- SCL=0, SDA=0.
- SCL=1, SDA=0.
- SCL=1, SDA=1.
REQ-029 After the STOP, the FSM SHALL return to IDLE; rsp_valid SHALL pulse for exactly 1 cycle in the first IDLE cycle, with rsp_rdata/rsp_nack held until the next accept.
REQ-030 Full-length write or read SHALL take 77 quarters; rsp_valid SHALL be high in cycle 77*CLK_DIV+1, counting the accept cycle as 0.
REQ-031 An address-NACK transaction SHALL take 41 quarters.
REQ-032 rsp_rdata SHALL be 0x00 for write transactions.
REQ-033 cmd_valid asserted in the same cycle rsp_valid pulses SHALL be accepted in that cycle (back-to-back), and rsp_valid still pulses.
REQ-034 sda_i SHALL be ignored outside its sample points; no clock stretching or arbitration-loss detection is performed.

Reset
REQ-035 When rst=1 on an edge, the block SHALL set:
- state=IDLE, scl_o=1, sda_o=1.
- busy=0, cmd_ready=1 from the next cycle.
- rsp_valid=0, rsp_rdata=0x00, rsp_nack=0.
- quarter and bit counters = 0.
REQ-036 Reset mid-transaction SHALL abort immediately with no STOP generated and no rsp_valid.
REQ-037 Reset SHALL override a simultaneous cmd_valid.

Structure
REQ-038 Package i2c_pkg SHALL hold the FSM state encoding, the quarter counts (START=2, BIT=4, STOP=3) and the bits-per-byte constant of 8.
REQ-039 The quarter-tick divider SHALL be one sub-module, i2c_qtick_gen (inputs clk, rst, en, clr; output tick).
REQ-040 The FSM, shift registers and output registers SHALL live in i2c_master_ctrl; scl_o/sda_o SHALL be registered.

Verification
REQ-041 Write addr=0x2A, wdata=0xA5, slave ACKs both -> SDA bytes 0x54 then 0xA5; rsp_nack=0; rsp_valid at cycle 309 with CLK_DIV=4.
REQ-042 Read addr=0x50, slave drives 0x3C -> address byte 0xA1, master NACK bit 1; rsp_rdata=0x3C, rsp_nack=0.
REQ-043 Addr=0x11 with no slave (SDA released) -> STOP after ADDR_ACK; rsp_nack=1; rsp_valid at cycle 41*4+1=165.
REQ-044 Write, slave NACKs the data byte -> full 77-quarter transaction; rsp_nack=1.
REQ-045 Hold cmd_valid continuously for two commands -> second accepted in the rsp_valid cycle; the START of the second command is the next bus activity.
REQ-046 Assert rst during ADDR bit 3 -> next cycle scl_o=1, sda_o=1, busy=0; no rsp_valid follows.
